// File: rtl/rgb_colour_decoder.sv
// Decodes 24-bit RGB pixels to a 3-bit colour code through a two-stage valid/ready pipeline.
// Also flags exact palette pixels and keeps a saturating count of non-exact ones.
module rgb_colour_decoder #(
  parameter logic [7:0]  THRESH = 8'h80,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      rgb,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       colour,
  output logic             exact,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clear,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [ERR_W-1:0] ErrMax = '1;

  logic [7:0] chan_r, chan_g, chan_b;
  logic [2:0] in_colour;
  logic       in_exact;

  logic       s1_valid;
  logic [2:0] s1_colour;
  logic       s1_exact;

  logic       s2_free;
  logic       accept;
  logic       advance;

  assign chan_r = rgb[23:16];
  assign chan_g = rgb[15:8];
  assign chan_b = rgb[7:0];

  always_comb begin
    in_colour = {chan_r >= THRESH, chan_g >= THRESH, chan_b >= THRESH};
    in_exact  = (chan_r == 8'h00 || chan_r == 8'hFF) &&
                (chan_g == 8'h00 || chan_g == 8'hFF) &&
                (chan_b == 8'h00 || chan_b == 8'hFF);
  end

  // Ready is combinational so a released stall accepts in the same cycle.
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid && s2_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_colour <= 3'b000;
      s1_exact  <= 1'b0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_colour <= in_colour;
      s1_exact  <= in_exact;
    end else if (advance) begin
      s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      colour    <= 3'b000;
      exact     <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b1;
      colour    <= s1_colour;
      exact     <= s1_exact;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear takes priority over a simultaneous non-exact accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (accept && !in_exact && err_count != ErrMax) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
